multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter OP_W, default 6, meaning opcode field width.
REQ-002 SHALL have parameter FUNCT_W, default 6, meaning R-type funct field width.
REQ-003 SHALL have parameter ALUCTRL_W, default 4, meaning alucontrol width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have ports op, input, OP_W, opcode; funct, input, FUNCT_W, funct field; zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, meaning memory completes the current access this cycle.
REQ-008 SHALL have 1-bit outputs iord, irwrite, memread, memwrite, regdst, memtoreg, regwrite, alusrca, pcen and illegal.
REQ-009 SHALL have 2-bit outputs alusrcb and pcsrc, and a ALUCTRL_W-bit output alucontrol.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB and JEX; all outputs not listed for a state SHALL be 0.
REQ-011 FETCH: iord=0, memread=1, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=add; irwrite=1 and pcen=1 only when mem_ready=1; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-012 DECODE: alusrca=0, alusrcb=11, alucontrol=add; next state by op: lw/sw 100011/101011 -> MEMADR, R-type 000000 -> RTYPEEX, beq 000100 -> BEQEX, addi 001000 -> ADDIEX, j 000010 -> JEX.
REQ-013 An unlisted op in DECODE SHALL pulse illegal=1 for that one cycle and return to FETCH with no register or memory write.
REQ-014 MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucontrol=add; MEMADR -> MEMRD for lw and MEMWR for sw; ADDIEX -> ADDIWB.
REQ-015 MEMRD: iord=1, memread=1; hold while mem_ready=0, then go to MEMWB; MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-016 MEMWR: iord=1, memwrite=1 held until mem_ready=1, then FETCH; memwrite SHALL never be asserted outside MEMWR.
REQ-017 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB; ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH; ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-018 funct map: 100000 add=0010, 100010 sub=0110, 100100 and=0000, 100101 or=0001, 101010 slt=0111; any other funct SHALL give alucontrol=0010 and pulse illegal in RTYPEEX.
REQ-019 BEQEX: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, pcen=zero -> FETCH; JEX: pcsrc=10, pcen=1 -> FETCH.
REQ-020 Per instruction, latency from FETCH with mem_ready=1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each mem_ready=0 cycle adds one.
REQ-021 op and funct SHALL be sampled only combinationally in the state that uses them; the FSM SHALL register no copy of them.

Reset
REQ-022 reset=1 at a clock edge SHALL force FETCH from any state, including mid-stall, and SHALL take precedence over mem_ready.
REQ-023 While in reset and on the first cycle after it, outputs SHALL equal FETCH values with mem_ready gating; regwrite, memwrite and illegal SHALL be 0.

Configuration
REQ-024 Macro CONTROLLER_BNE_EN SHALL add state BNEEX: op 000101 in DECODE -> BNEEX, same outputs as BEQEX except pcen=~zero, -> FETCH.
REQ-025 Without CONTROLLER_BNE_EN, op 000101 SHALL be illegal per REQ-013.

Structure
REQ-026 Package controller_pkg SHALL hold the state enum, opcode and funct constants, alucontrol codes and pcsrc/alusrcb encodings.
REQ-027 Funct-to-alucontrol decoding SHALL be a combinational sub-module alu_decoder; the FSM and output decode SHALL stay in multicycle_controller.

Verification
REQ-028 Scenario: reset, then lw (100011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-029 Scenario: sw with mem_ready low for 3 cycles in MEMWR -> memwrite high for 4 cycles, then FETCH; total 7 cycles.
REQ-030 Scenario: R-type funct 100010 -> alucontrol=0110 in RTYPEEX; funct 111111 -> illegal pulse, alucontrol=0010.
REQ-031 Scenario: beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; j -> pcsrc=10, pcen=1.
REQ-032 Scenario: op 000101 -> BNEEX with pcen=~zero when CONTROLLER_BNE_EN is defined, else illegal pulse in DECODE.
REQ-033 Scenario: reset asserted during a MEMRD stall -> FETCH on the next edge with regwrite=0 and no MEMWB.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle controller: state enum, opcode/funct
// constants, ALU control codes and the pcsrc/alusrcb mux selects.
package controller_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct to ALU control decode; unknown funct codes
// fall back to add and raise the illegal flag.
module alu_decoder
   import controller_pkg::*;
#(
   parameter int FUNCT_W   = 6,
   parameter int ALUCTRL_W = 4
) (
   input  logic [FUNCT_W-1:0]   funct,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 illegal
);

   always_comb begin
      alucontrol = ALUCTRL_W'(ALU_ADD);
      illegal    = 1'b0;
      case (funct)
         FUNCT_W'(FUNCT_ADD): alucontrol = ALUCTRL_W'(ALU_ADD);
         FUNCT_W'(FUNCT_SUB): alucontrol = ALUCTRL_W'(ALU_SUB);
         FUNCT_W'(FUNCT_AND): alucontrol = ALUCTRL_W'(ALU_AND);
         FUNCT_W'(FUNCT_OR):  alucontrol = ALUCTRL_W'(ALU_OR);
         FUNCT_W'(FUNCT_SLT): alucontrol = ALUCTRL_W'(ALU_SLT);
         default:             illegal    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with memory handshake stalls.
// Define CONTROLLER_BNE_EN to add the bne instruction (state BNEEX).
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int OP_W      = 6,
   parameter int FUNCT_W   = 6,
   parameter int ALUCTRL_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_W-1:0]      op,
   input  logic [FUNCT_W-1:0]   funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 iord,
   output logic                 irwrite,
   output logic                 memread,
   output logic                 memwrite,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic                 pcen,
   output logic                 illegal,
   output logic [1:0]           alusrcb,
   output logic [1:0]           pcsrc,
   output logic [ALUCTRL_W-1:0] alucontrol
);

   state_t                 state_reg;
   state_t                 state_next;
   state_t                 state_cur;
   logic [ALUCTRL_W-1:0]   funct_alucontrol;
   logic                   funct_illegal;

   alu_decoder #(
      .FUNCT_W   (FUNCT_W),
      .ALUCTRL_W (ALUCTRL_W)
   ) u_alu_decoder (
      .funct      (funct),
      .alucontrol (funct_alucontrol),
      .illegal    (funct_illegal)
   );

   // Outputs look like FETCH while reset is held, whatever state is stored.
   assign state_cur = reset ? FETCH : state_reg;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= FETCH;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      pcen       = 1'b0;
      illegal    = 1'b0;
      alusrcb    = SRCB_REG;
      pcsrc      = PCSRC_ALU;
      alucontrol = '0;
      case (state_cur)
         FETCH: begin
            memread    = 1'b1;
            alusrcb    = SRCB_FOUR;
            alucontrol = ALUCTRL_W'(ALU_ADD);
            irwrite    = mem_ready;
            pcen       = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb    = SRCB_IMMSH;
            alucontrol = ALUCTRL_W'(ALU_ADD);
            case (op)
               OP_W'(OP_LW), OP_W'(OP_SW): state_next = MEMADR;
               OP_W'(OP_RTYPE):            state_next = RTYPEEX;
               OP_W'(OP_BEQ):              state_next = BEQEX;
               OP_W'(OP_ADDI):             state_next = ADDIEX;
               OP_W'(OP_J):                state_next = JEX;
`ifdef CONTROLLER_BNE_EN
               OP_W'(OP_BNE):              state_next = BNEEX;
`endif
               default: begin
                  illegal    = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR, ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            alucontrol = ALUCTRL_W'(ALU_ADD);
            if (state_cur == ADDIEX)      state_next = ADDIWB;
            else if (op == OP_W'(OP_SW))  state_next = MEMWR;
            else                          state_next = MEMRD;
         end
         MEMRD: begin
            iord       = 1'b1;
            memread    = 1'b1;
            state_next = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            state_next = mem_ready ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_alucontrol;
            illegal    = funct_illegal;
            state_next = ALUWB;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         ADDIWB: regwrite = 1'b1;
         BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = ALUCTRL_W'(ALU_SUB);
            pcsrc      = PCSRC_ALUOUT;
            pcen       = zero;
         end
`ifdef CONTROLLER_BNE_EN
         BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALUCTRL_W'(ALU_SUB);
            pcsrc      = PCSRC_ALUOUT;
            pcen       = ~zero;
         end
`endif
         JEX: begin
            pcsrc = PCSRC_JUMP;
            pcen  = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction reference model
// pushes expected per-cycle control words; a negedge monitor pops and compares.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] op, funct;
   logic       iord, irwrite, memread, memwrite, regdst, memtoreg, regwrite;
   logic       alusrca, pcen, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite), .memread(memread),
      .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .pcen(pcen), .illegal(illegal),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
   );

   typedef struct packed {
      logic iord, irwrite, memread, memwrite, regdst, memtoreg, regwrite;
      logic alusrca, pcen, illegal;
      logic [1:0] alusrcb, pcsrc;
      logic [3:0] alucontrol;
   } outs_t;

   typedef struct {
      outs_t exp;
      string name;
   } item_t;

   item_t sbq[$];
   int    checks = 0;
   int    failures = 0;
   outs_t act;

   assign act = {iord, irwrite, memread, memwrite, regdst, memtoreg, regwrite,
                 alusrca, pcen, illegal, alusrcb, pcsrc, alucontrol};

   always @(negedge clk) begin
      item_t it;
      if (sbq.size() > 0) begin
         it = sbq.pop_front();
         checks++;
         if (act !== it.exp) begin
            failures++;
            $display("FAIL %s op=%b funct=%b: got %b required %b",
                     it.name, op, funct, act, it.exp);
         end else begin
            $display("ok   %s op=%b word=%b", it.name, op, act);
         end
      end
   end

   // Reference model: control words derived directly from the instruction rules.
   function automatic outs_t o_fetch(logic mr);
      outs_t e = '0;
      e.memread = 1'b1; e.alusrcb = 2'b01; e.alucontrol = 4'b0010;
      e.irwrite = mr;   e.pcen = mr;
      return e;
   endfunction

   function automatic outs_t o_decode(logic ill);
      outs_t e = '0;
      e.alusrcb = 2'b11; e.alucontrol = 4'b0010; e.illegal = ill;
      return e;
   endfunction

   function automatic outs_t o_addr();
      outs_t e = '0;
      e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 4'b0010;
      return e;
   endfunction

   function automatic outs_t o_mem(logic wr);
      outs_t e = '0;
      e.iord = 1'b1; e.memread = ~wr; e.memwrite = wr;
      return e;
   endfunction

   function automatic outs_t o_wb(logic from_mem, logic rd_field);
      outs_t e = '0;
      e.regwrite = 1'b1; e.memtoreg = from_mem; e.regdst = rd_field;
      return e;
   endfunction

   function automatic logic [4:0] ref_alu(logic [5:0] f);
      case (f)
         6'b100000: return 5'b0_0010;
         6'b100010: return 5'b0_0110;
         6'b100100: return 5'b0_0000;
         6'b100101: return 5'b0_0001;
         6'b101010: return 5'b0_0111;
         default:   return 5'b1_0010;
      endcase
   endfunction

   function automatic outs_t o_rex(logic [5:0] f);
      outs_t      e = '0;
      logic [4:0] r = ref_alu(f);
      e.alusrca = 1'b1; e.alucontrol = r[3:0]; e.illegal = r[4];
      return e;
   endfunction

   function automatic outs_t o_branch(logic taken);
      outs_t e = '0;
      e.alusrca = 1'b1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01; e.pcen = taken;
      return e;
   endfunction

   function automatic outs_t o_jump();
      outs_t e = '0;
      e.pcsrc = 2'b10; e.pcen = 1'b1;
      return e;
   endfunction

   function automatic bit op_legal(logic [5:0] o);
`ifdef CONTROLLER_BNE_EN
      if (o == 6'b000101) return 1'b1;
`endif
      return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input logic r, input logic mr, input logic z,
                       input logic [5:0] o, input logic [5:0] f,
                       input outs_t e, input string nm);
      item_t it;
      reset = r; mem_ready = mr; zero = z; op = o; funct = f;
      it.exp = e; it.name = nm;
      sbq.push_back(it);
      @(posedge clk); #1;
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fstall, input int mstall, input bit rst_memrd);
      logic mr;
      for (int i = 0; i < fstall; i++)
         step(0, 0, rb(), 6'($urandom), 6'($urandom), o_fetch(0), "fetch_stall");
      step(0, 1, rb(), 6'($urandom), 6'($urandom), o_fetch(1), "fetch");
      if (!op_legal(o)) begin
         step(0, rb(), rb(), o, f, o_decode(1), "decode_illegal");
         return;
      end
      step(0, rb(), rb(), o, f, o_decode(0), "decode");
      if (o == 6'b100011) begin
         step(0, rb(), rb(), o, f, o_addr(), "memadr_lw");
         for (int i = 0; i < mstall; i++)
            step(0, 0, rb(), o, f, o_mem(0), "memrd_stall");
         if (rst_memrd) begin
            mr = rb();
            step(1, mr, rb(), o, f, o_fetch(mr), "reset_in_memrd");
            return;
         end
         step(0, 1, rb(), o, f, o_mem(0), "memrd");
         step(0, rb(), rb(), o, f, o_wb(1, 0), "memwb");
      end else if (o == 6'b101011) begin
         step(0, rb(), rb(), o, f, o_addr(), "memadr_sw");
         for (int i = 0; i < mstall; i++)
            step(0, 0, rb(), o, f, o_mem(1), "memwr_stall");
         step(0, 1, rb(), o, f, o_mem(1), "memwr");
      end else if (o == 6'b000000) begin
         step(0, rb(), rb(), o, f, o_rex(f), "rtypeex");
         step(0, rb(), rb(), o, 6'($urandom), o_wb(0, 1), "aluwb");
      end else if (o == 6'b000100) begin
         step(0, rb(), z, o, f, o_branch(z), "beqex");
      end else if (o == 6'b000101) begin
         step(0, rb(), z, o, f, o_branch(~z), "bneex");
      end else if (o == 6'b001000) begin
         step(0, rb(), rb(), o, f, o_addr(), "addiex");
         step(0, rb(), rb(), o, f, o_wb(0, 0), "addiwb");
      end else begin
         step(0, rb(), rb(), o, f, o_jump(), "jex");
      end
   endtask

   logic [5:0] legal_ops  [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b001000, 6'b000010, 6'b000101};
   logic [5:0] legal_fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      logic [5:0] o, f;
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
      @(posedge clk); #1;
      step(1, 0, 0, 6'b100011, 6'b0, o_fetch(0), "reset_mr0");
      step(1, 1, 1, 6'b101011, 6'b0, o_fetch(1), "reset_mr1");

      run_instr(6'b100011, 6'b000000, 0, 0, 0, 0);   // lw, no stalls
      run_instr(6'b101011, 6'b000000, 0, 0, 3, 0);   // sw, 3 stalls in MEMWR
      run_instr(6'b000000, 6'b100010, 0, 0, 0, 0);   // R-type sub
      run_instr(6'b000000, 6'b111111, 0, 0, 0, 0);   // R-type illegal funct
      run_instr(6'b000100, 6'b000000, 1, 0, 0, 0);   // beq taken
      run_instr(6'b000100, 6'b000000, 0, 1, 0, 0);   // beq not taken, fetch stall
      run_instr(6'b000010, 6'b000000, 0, 0, 0, 0);   // j
      run_instr(6'b000101, 6'b000000, 0, 0, 0, 0);   // bne / illegal
      run_instr(6'b000101, 6'b000000, 1, 0, 0, 0);
      run_instr(6'b100011, 6'b000000, 0, 0, 2, 1);   // reset mid MEMRD stall
      run_instr(6'b001000, 6'b000000, 0, 0, 0, 0);   // addi
      run_instr(6'b111111, 6'b000000, 0, 0, 0, 0);   // unlisted op

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 6)];
         else                         o = 6'($urandom);
         if ($urandom_range(0, 3) != 0) f = legal_fns[$urandom_range(0, 4)];
         else                          f = 6'($urandom);
         run_instr(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0));
      end

      @(negedge clk); #1;
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
